// File: rtl/i2s_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_frame_scheduler
//  Function : bclk/lrclk generation, per-frame source arbitration, capture
//             with attenuation and underrun tracking for the I2S transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_frame_scheduler #(
  parameter int SAMPLE_W  = 16,
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            src_sel,
  input  logic [3:0]            atten,
  input  logic [2:0]            src_valid,
  input  logic [3*SAMPLE_W-1:0] src_data,
  output logic [2:0]            src_ready,
  input  logic                  clr_underrun,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  frame_start,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  underrun,
  output logic [7:0]            underrun_cnt
);

  localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int c_BIT_W = $clog2(2*SLOT_BITS);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV-1);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BCLK_DIV/2);
  localparam logic [c_DIV_W-1:0] c_DIV_PRE  = c_DIV_W'(BCLK_DIV/2-1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2*SLOT_BITS-1);
  localparam logic [c_BIT_W-1:0] c_BIT_DL   = c_BIT_W'(2*SLOT_BITS-3);
  localparam logic [c_BIT_W-1:0] c_BIT_SLOT = c_BIT_W'(SLOT_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  logic [c_DIV_W-1:0]          r_div;
  logic [c_BIT_W-1:0]          r_bit;
  logic                        r_started;
  logic                        r_fs;
  logic [1:0]                  r_sel_q;
  logic [3:0]                  r_atten_q;
  logic [2:0]                  r_ready;
  logic [SAMPLE_W-1:0]         r_pend;
  logic [SAMPLE_W-1:0]         r_sample;
  logic                        r_underrun;
  logic [7:0]                  r_cnt;

  logic                        w_fall;
  logic                        w_capture;
  logic                        w_deadline;
  logic                        w_underrun;
  logic signed [SAMPLE_W-1:0]  w_word;
  logic signed [SAMPLE_W-1:0]  w_shifted;

  always_comb begin
    w_word = '0;
    case (r_sel_q)
      2'd0:    w_word = src_data[0*SAMPLE_W +: SAMPLE_W];
      2'd1:    w_word = src_data[1*SAMPLE_W +: SAMPLE_W];
      2'd2:    w_word = src_data[2*SAMPLE_W +: SAMPLE_W];
      default: w_word = '0;
    endcase
  end

  assign w_shifted  = w_word >>> r_atten_q;
  assign w_fall     = enable && (r_div == c_DIV_LAST);
  // src_ready is one-hot on sel_q while waiting, so it doubles as the source mux
  assign w_capture  = (r_state == S_WAIT) && |(src_valid & r_ready);
  assign w_deadline = (r_state == S_WAIT) && w_fall && (r_bit == c_BIT_DL);
  assign w_underrun = w_deadline && !w_capture && (r_sel_q != 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_started  <= 1'b0;
      r_fs       <= 1'b0;
      r_sel_q    <= 2'd0;
      r_atten_q  <= 4'd0;
      r_ready    <= 3'd0;
      r_pend     <= '0;
      r_sample   <= '0;
      r_underrun <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      // Underrun bookkeeping survives enable=0; a coincident new underrun beats clear
      if (w_underrun) begin
        r_underrun <= 1'b1;
        if (clr_underrun)
          r_cnt <= 8'd1;
        else if (r_cnt != 8'hFF)
          r_cnt <= r_cnt + 8'd1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
        r_cnt      <= 8'd0;
      end

      if (!enable) begin
        r_state   <= S_IDLE;
        r_div     <= '0;
        r_bit     <= '0;
        r_started <= 1'b0;
        r_fs      <= 1'b0;
        r_sel_q   <= 2'd0;
        r_atten_q <= 4'd0;
        r_ready   <= 3'd0;
        r_pend    <= '0;
        r_sample  <= '0;
      end else begin
        r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        r_fs  <= 1'b0;
        if (w_fall) begin
          r_started <= 1'b1;
          if (!r_started || (r_bit == c_BIT_LAST)) begin
            r_bit <= '0;
            r_fs  <= 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end

        // Update coincides with bclk rising in the last bit of the frame
        if ((r_bit == c_BIT_LAST) && (r_div == c_DIV_PRE))
          r_sample <= r_pend;

        case (r_state)
          S_IDLE, S_HOLD: begin
            if (r_fs) begin
              r_state   <= S_WAIT;
              r_sel_q   <= src_sel;
              r_atten_q <= atten;
              // mute (sel=3) shifts the one-hot out entirely
              r_ready   <= 3'b001 << src_sel;
            end
          end
          S_WAIT: begin
            if (w_capture) begin
              r_pend  <= w_shifted;
              r_ready <= 3'd0;
              r_state <= S_HOLD;
            end else if (w_deadline) begin
              if (r_sel_q == 2'd3)
                r_pend <= '0;
              r_ready <= 3'd0;
              r_state <= S_HOLD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bclk         = (r_div >= c_DIV_HALF);
  assign lrclk        = (r_bit >= c_BIT_SLOT);
  assign frame_start  = r_fs;
  assign src_ready    = r_ready;
  assign sample_out   = r_sample;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_scheduler.sv
`default_nettype none
// Bench for i2s_frame_scheduler: cycle-count reference model plus directed
// and randomized frames; a second small instance exercises count saturation.
module tb_i2s_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, clr;
  logic [1:0]  sel;
  logic [3:0]  att;
  logic [2:0]  vld;
  logic [47:0] data;
  logic [2:0]  ready;
  logic        bclk, lrclk, fs, uf;
  logic [15:0] sample;
  logic [7:0]  cnt;

  logic        s_rst_n, s_en, s_clr;
  logic [1:0]  s_sel;
  logic [3:0]  s_att;
  logic [2:0]  s_vld;
  logic [47:0] s_data;
  logic [2:0]  s_ready;
  logic        s_bclk, s_lrclk, s_fs, s_uf;
  logic [15:0] s_sample;
  logic [7:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  i2s_frame_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_sel(sel), .atten(att),
    .src_valid(vld), .src_data(data), .src_ready(ready), .clr_underrun(clr),
    .bclk(bclk), .lrclk(lrclk), .frame_start(fs), .sample_out(sample),
    .underrun(uf), .underrun_cnt(cnt)
  );

  i2s_frame_scheduler #(.SAMPLE_W(16), .BCLK_DIV(4), .SLOT_BITS(4)) u_sat (
    .clk(clk), .rst_n(s_rst_n), .enable(s_en), .src_sel(s_sel), .atten(s_att),
    .src_valid(s_vld), .src_data(s_data), .src_ready(s_ready), .clr_underrun(s_clr),
    .bclk(s_bclk), .lrclk(s_lrclk), .frame_start(s_fs), .sample_out(s_sample),
    .underrun(s_uf), .underrun_cnt(s_cnt)
  );

  // Reference model: everything timing-related derives from n = enabled clk edges
  int          m_n;
  bit          m_wait;
  logic [1:0]  m_selq;
  logic [3:0]  m_attq;
  logic [15:0] m_pend, m_sample;
  bit          m_uf;
  int          m_uc;

  function automatic int bitof(int n);
    return (n < 8) ? 0 : ((n / 8 - 1) % 64);
  endfunction

  function automatic bit fs_at(int n);
    return (n >= 8) && (n % 8 == 0) && (bitof(n) == 0);
  endfunction

  function automatic logic [15:0] lane(logic [47:0] d, logic [1:0] s);
    case (s)
      2'd0:    return d[15:0];
      2'd1:    return d[31:16];
      2'd2:    return d[47:32];
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int nn;
    bit fall, dl, cap, uev, fsn;
    logic [3:0] v4;
    if (!rst_n) begin
      m_n = 0; m_wait = 0; m_selq = 0; m_attq = 0;
      m_pend = 0; m_sample = 0; m_uf = 0; m_uc = 0;
    end else begin
      nn   = m_n + 1;
      v4   = {1'b0, vld};
      fall = enable && (nn % 8 == 0);
      dl   = m_wait && fall && (bitof(nn) == 62);
      cap  = m_wait && (m_selq != 2'd3) && v4[m_selq];
      uev  = dl && !cap && (m_selq != 2'd3);
      if (uev) begin
        m_uf = 1;
        m_uc = clr ? 1 : ((m_uc < 255) ? m_uc + 1 : 255);
      end else if (clr) begin
        m_uf = 0; m_uc = 0;
      end
      if (!enable) begin
        m_n = 0; m_wait = 0; m_selq = 0; m_attq = 0; m_pend = 0; m_sample = 0;
      end else begin
        fsn = fs_at(m_n);
        if ((nn % 8 == 4) && (bitof(nn) == 63)) m_sample = m_pend;
        if (cap) begin
          m_pend = $signed(lane(data, m_selq)) >>> m_attq;
          m_wait = 0;
        end else if (dl) begin
          if (m_selq == 2'd3) m_pend = 0;
          m_wait = 0;
        end else if (fsn && !m_wait) begin
          m_wait = 1; m_selq = sel; m_attq = att;
        end
        m_n = nn;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0]  e_ready;
    logic [30:0] e_vec, a_vec;
    e_ready = (m_wait && m_selq != 2'd3) ? 3'(3'b001 << m_selq) : 3'b000;
    e_vec = {(m_n % 8) >= 4, bitof(m_n) >= 32, fs_at(m_n), e_ready, m_sample, m_uf, 8'(m_uc)};
    a_vec = {bclk, lrclk, fs, ready, sample, uf, cnt};
    vectors++;
    if (a_vec !== e_vec) begin
      miscompares++;
      $display("FAIL cycle n=%0d {bclk,lr,fs,rdy,smp,uf,cnt}: got %h expected %h", m_n, a_vec, e_vec);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fs(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fs) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_fs: no frame_start within %0d clk", cyc);
  endtask

  initial begin
    int c, t, u, cc, nfs;
    bit got;
    rst_n = 0; enable = 1; clr = 0; sel = 2'd3; att = 0; vld = 0; data = 0;
    s_rst_n = 0; s_en = 0; s_clr = 0; s_sel = 2'd1; s_att = 0; s_vld = 0; s_data = 0;

    tick(3);
    chk("rst_outputs", {bclk, lrclk, fs, ready, sample, uf, cnt}, 32'h0);
    rst_n = 1;
    wait_fs(c);  chk("first_fs_clk", c, 8);
    wait_fs(c);  chk("frame_len", c, 512);
    tick(255);   chk("lrclk_before_32_falls", lrclk, 0);
    tick(1);     chk("lrclk_after_32_falls", lrclk, 1);
    wait_fs(c);  chk("frame_len_2", c, 256);

    // capture on FIR path
    sel = 2'd1; att = 0;
    tick(40);    chk("ready_fir", ready, 3'b010);
    vld = 3'b010; data[31:16] = 16'h1234;
    tick(1);     vld = 0; chk("ready_drop", ready, 0);
    wait_fs(c);  chk("sample_1234", sample, 16'h1234);

    // attenuation on IIR path
    sel = 2'd2; att = 4'd2;
    tick(40);    vld = 3'b100; data[47:32] = 16'h8000;
    tick(1);     vld = 0;
    wait_fs(c);  chk("sample_atten", sample, 16'hE000);

    // underrun, then clear coincident with a second underrun
    sel = 2'd1; att = 0;
    tick(400);   chk("sample_held", sample, 16'hE000);
    wait_fs(c);
    chk("underrun_flag", uf, 1);
    chk("underrun_cnt1", cnt, 1);
    chk("sample_repeat", sample, 16'hE000);
    tick(495);   clr = 1;
    tick(1);     clr = 0; chk("clr_vs_set_cnt", cnt, 1);

    // select change mid-frame then mute
    sel = 2'd0;
    wait_fs(c);
    tick(100);   sel = 2'd3;
    tick(100);   chk("old_source_ready", ready, 3'b001);
    vld = 3'b001; data[15:0] = 16'h0BEE;
    tick(1);     vld = 0;
    wait_fs(c);  chk("sample_old_src", sample, 16'h0BEE);
    tick(10);    chk("mute_ready", ready, 0);
    sel = 2'd0;
    wait_fs(c);
    chk("mute_sample", sample, 0);
    chk("mute_no_underrun", cnt, 1);

    // abort mid-frame
    tick(40);    vld = 3'b001; data[15:0] = 16'h5555;
    tick(1);     vld = 0; sel = 2'd2;
    wait_fs(c);  chk("sample_5555", sample, 16'h5555);
    tick(160);   chk("ready_before_abort", ready, 3'b100);
    enable = 0;
    tick(1);     chk("abort_outputs", {bclk, lrclk, sample, ready}, 0);
    tick(5);     enable = 1;
    wait_fs(c);  chk("reenable_fs_clk", c, 8);
    chk("cnt_kept_over_disable", cnt, 1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      sel = 2'($urandom); att = 4'($urandom);
      t  = $urandom_range(1, 700);
      u  = $urandom_range(1, 511);
      cc = $urandom_range(1, 2000);
      got = 0;
      for (int k = 1; k <= 600 && !got; k++) begin
        @(negedge clk);
        vld = 0; clr = 0; rst_n = 1;
        if (fs) got = 1;
        else begin
          if (k == t) begin vld = 3'($urandom); data = 48'({$urandom, $urandom}); end
          if (k == u) begin sel = 2'($urandom); att = 4'($urandom); end
          if (k == cc) clr = 1;
          if (f == 15 && k == 300) rst_n = 0;
        end
      end
      if (!got) begin
        vectors++; miscompares++;
        $display("FAIL random_frame %0d: no frame_start", f);
      end
    end

    // saturation on a short-frame instance (32 clk frames)
    s_rst_n = 1; s_en = 1; nfs = 0;
    for (int k = 0; k < 12000 && nfs < 300; k++) begin
      @(negedge clk);
      if (s_fs) begin
        nfs++;
        if (nfs == 50)  chk("sat_cnt_49", s_cnt, 49);
        if (nfs == 270) chk("sat_cnt_270", s_cnt, 255);
      end
    end
    chk("sat_frames_seen", nfs, 300);
    tick(40);
    chk("sat_cnt_255", s_cnt, 255);
    chk("sat_flag", s_uf, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
